// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } arb_owner_t;

    localparam int WCNT_WIDTH = 4;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection between fetch and load/store requests.
module mem_arb_select (
    input  logic if_req,
    input  logic ls_req,
    input  logic last_is_ls,
    output logic req_any,
    output logic ls_wins
);

    // A contested request goes to whoever did not win last; tying last_is_ls low gives LS priority.
    always_comb begin
        req_any = if_req | ls_req;
        ls_wins = ls_req;
        if (if_req && ls_req) begin
            ls_wins = ~last_is_ls;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate contested grants instead of fixed LS priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [ADDR_WIDTH-1:0] ls_addr_i,
    input  logic [DATA_WIDTH-1:0] ls_wdata_i,
    output logic                  ls_gnt_o,
    output logic                  ls_rvalid_o,
    output logic [DATA_WIDTH-1:0] ls_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o
);

    localparam logic [WCNT_WIDTH-1:0] WCNT_LOAD = WCNT_WIDTH'(WAIT_STATES);

    arb_state_t            state;
    arb_state_t            state_nxt;
    arb_owner_t            owner;
    arb_owner_t            last_owner;
    logic [WCNT_WIDTH-1:0] wcnt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] ls_rdata_q;
    logic                  req_any;
    logic                  ls_wins;
    logic                  grant;
    logic                  last_busy;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= OWN_IF;
        end else if (grant) begin
            last_owner <= ls_wins ? OWN_LS : OWN_IF;
        end
    end
`else
    assign last_owner = OWN_IF;
`endif

    mem_arb_select u_select (
        .if_req     (if_req_i),
        .ls_req     (ls_req_i),
        .last_is_ls (last_owner == OWN_LS),
        .req_any    (req_any),
        .ls_wins    (ls_wins)
    );

    // Grants are suppressed while reset is asserted so nothing is handed out that cannot start.
    assign grant     = (state == ARB_IDLE) && req_any && !reset;
    assign last_busy = (state == ARB_BUSY) && (wcnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        if_gnt_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        ls_rvalid_o = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        busy_o      = (state != ARB_IDLE);
        case (state)
            ARB_IDLE: begin
                if (grant) begin
                    ls_gnt_o  = ls_wins;
                    if_gnt_o  = ~ls_wins;
                    state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                mem_en_o = 1'b1;
                if (last_busy) begin
                    mem_we_o  = lat_we;
                    state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                ls_rvalid_o = (owner == OWN_LS);
                if_rvalid_o = (owner == OWN_IF);
                state_nxt   = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Transaction registers and per-requester read data; a write leaves both rdata registers alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_IF;
            wcnt       <= '0;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if (grant) begin
                owner     <= ls_wins ? OWN_LS : OWN_IF;
                wcnt      <= WCNT_LOAD;
                lat_addr  <= ls_wins ? ls_addr_i : if_addr_i;
                lat_we    <= ls_wins & ls_we_i;
                lat_wdata <= ls_wins ? ls_wdata_i : '0;
            end else if ((state == ARB_BUSY) && (wcnt != '0)) begin
                wcnt <= wcnt - 1'b1;
            end
            if (last_busy && !lat_we) begin
                if (owner == OWN_LS) begin
                    ls_rdata_q <= mem_rdata_i;
                end else begin
                    if_rdata_q <= mem_rdata_i;
                end
            end
        end
    end

    assign mem_addr_o  = lat_addr;
    assign mem_wdata_o = lat_wdata;
    assign if_rdata_o  = if_rdata_q;
    assign ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// compared against a transaction-timeline model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WS = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          ls_req_i;
    logic          ls_we_i;
    logic [AW-1:0] ls_addr_i;
    logic [DW-1:0] ls_wdata_i;
    logic          ls_gnt_o;
    logic          ls_rvalid_o;
    logic [DW-1:0] ls_rdata_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          busy_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .WAIT_STATES (WS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .ls_req_i    (ls_req_i),
        .ls_we_i     (ls_we_i),
        .ls_addr_i   (ls_addr_i),
        .ls_wdata_i  (ls_wdata_i),
        .ls_gnt_o    (ls_gnt_o),
        .ls_rvalid_o (ls_rvalid_o),
        .ls_rdata_o  (ls_rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: a transaction is a timeline counted in cycles since its grant.
    bit          m_active = 1'b0;
    bit          m_owner_ls = 1'b0;
    int          m_age = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    bit          m_we = 1'b0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_ls_rdata = '0;
    bit          m_last_ls = 1'b0;
    logic        exp_if_gnt = 1'b0;
    logic        exp_ls_gnt = 1'b0;

    int we_seen = 0;
    int ls_rv_seen = 0;
    int if_gnt_cyc = -1;
    int ls_gnt_cyc = -1;
    int if_rv_cyc = -1;
    int base = 0;
    bit gnt_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic bit model_ls_wins(input bit ifr, input bit lsr);
        if (ifr && lsr) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return !m_last_ls;
`else
            return 1'b1;
`endif
        end
        return lsr;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, advance the model at the rising edge.
    task automatic applyStimulus(input logic rst, input logic ifr, input logic [31:0] ifa,
                                 input logic lsr, input logic lswe, input logic [31:0] lsa,
                                 input logic [31:0] lswd);
        bit lsw;
        bit g;
        bit in_busy;
        bit in_resp;
        reset      = rst;
        if_req_i   = ifr;
        if_addr_i  = ifa;
        ls_req_i   = lsr;
        ls_we_i    = lswe;
        ls_addr_i  = lsa;
        ls_wdata_i = lswd;
        if (m_active && m_age == 1 + WS) mem_rdata_i = mem_word(m_addr);
        else mem_rdata_i = $urandom;
        @(negedge clk);
        lsw        = model_ls_wins(ifr, lsr);
        g          = !m_active && !rst && (ifr || lsr);
        exp_ls_gnt = g && lsw;
        exp_if_gnt = g && !lsw;
        in_busy    = m_active && (m_age <= 1 + WS);
        in_resp    = m_active && (m_age == 2 + WS);
        checkOutput("if_gnt", 32'(if_gnt_o), 32'(exp_if_gnt));
        checkOutput("ls_gnt", 32'(ls_gnt_o), 32'(exp_ls_gnt));
        checkOutput("mem_en", 32'(mem_en_o), 32'(in_busy));
        checkOutput("mem_we", 32'(mem_we_o), 32'(in_busy && m_we && (m_age == 1 + WS)));
        checkOutput("busy", 32'(busy_o), 32'(m_active));
        checkOutput("if_rvalid", 32'(if_rvalid_o), 32'(in_resp && !m_owner_ls));
        checkOutput("ls_rvalid", 32'(ls_rvalid_o), 32'(in_resp && m_owner_ls));
        checkOutput("if_rdata", if_rdata_o, m_if_rdata);
        checkOutput("ls_rdata", ls_rdata_o, m_ls_rdata);
        if (in_busy) checkOutput("mem_addr", mem_addr_o, m_addr);
        if (in_busy && m_we) checkOutput("mem_wdata", mem_wdata_o, m_wdata);
        if (mem_we_o) we_seen++;
        if (ls_rvalid_o) ls_rv_seen++;
        if (if_gnt_o) begin if_gnt_cyc = cyc; gnt_log.push_back(1'b0); end
        if (ls_gnt_o) begin ls_gnt_cyc = cyc; gnt_log.push_back(1'b1); end
        if (if_rvalid_o) if_rv_cyc = cyc;
        @(posedge clk);
        if (rst) begin
            m_active   = 1'b0;
            m_if_rdata = '0;
            m_ls_rdata = '0;
            m_last_ls  = 1'b0;
        end else if (!m_active) begin
            if (g) begin
                m_active   = 1'b1;
                m_age      = 1;
                m_owner_ls = lsw;
                m_addr     = lsw ? lsa : ifa;
                m_we       = lsw && lswe;
                m_wdata    = lswd;
                m_last_ls  = lsw;
            end
        end else begin
            if (m_age == 1 + WS && !m_we) begin
                if (m_owner_ls) m_ls_rdata = mem_rdata_i;
                else m_if_rdata = mem_rdata_i;
            end
            if (m_age == 2 + WS) m_active = 1'b0;
            else m_age++;
        end
        #1;
        cyc++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        bit ifq;
        bit lsq;
        reset = 1'b1; if_req_i = 1'b0; if_addr_i = '0; ls_req_i = 1'b0; ls_we_i = 1'b0;
        ls_addr_i = '0; ls_wdata_i = '0; mem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("rst_mem_addr", mem_addr_o, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata_o, 32'd0);

        // Single fetch
        base = cyc; if_gnt_cyc = -1; if_rv_cyc = -1;
        applyStimulus(1'b0, 1'b1, 32'h0040_0000, 1'b0, 1'b0, '0, '0);
        idleCycles(4);
        checkOutput("fetch_gnt_cycle", if_gnt_cyc - base, 32'd0);
        checkOutput("fetch_rvalid_cycle", if_rv_cyc - base, 32'd3);
        checkOutput("fetch_rdata", if_rdata_o, 32'h0000_0013);

        // Store
        we_seen = 0; ls_rv_seen = 0;
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF);
        idleCycles(4);
        checkOutput("store_we_count", we_seen, 32'd1);
        checkOutput("store_rvalid_count", ls_rv_seen, 32'd1);
        checkOutput("store_ls_rdata", ls_rdata_o, 32'd0);

        // Contention: each requester holds until granted
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        base = cyc; if_gnt_cyc = -1; ls_gnt_cyc = -1;
        ifq = 1'b1; lsq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, ifq, 32'h0040_0100, lsq, 1'b0, 32'h1001_0040, '0);
            if (exp_if_gnt) ifq = 1'b0;
            if (exp_ls_gnt) lsq = 1'b0;
        end
        checkOutput("contend_ls_gnt_cycle", ls_gnt_cyc - base, 32'd0);
        checkOutput("contend_if_gnt_cycle", if_gnt_cyc - base, 32'd4);

        // Reset mid-store
        we_seen = 0; ls_rv_seen = 0;
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h1001_0000, 32'h1234_5678);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("rst_mid_busy", 32'(busy_o), 32'd0);
        idleCycles(4);
        checkOutput("rst_mid_we_count", we_seen, 32'd0);
        checkOutput("rst_mid_rvalid_count", ls_rv_seen, 32'd0);

        // Fetch request held while a load is in flight
        base = cyc; if_gnt_cyc = -1; if_rv_cyc = -1;
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h1001_0080, '0);
        ifq = 1'b1;
        for (int i = 1; i < 10; i++) begin
            applyStimulus(1'b0, ifq, 32'h0040_0200, 1'b0, 1'b0, '0, '0);
            if (exp_if_gnt) ifq = 1'b0;
        end
        checkOutput("held_if_gnt_cycle", if_gnt_cyc - base, 32'd4);
        checkOutput("held_if_rvalid_cycle", if_rv_cyc - base, 32'd7);
        checkOutput("held_ls_rdata", ls_rdata_o, mem_word(32'h1001_0080));

        // Both requests held continuously for four transactions
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        gnt_log.delete();
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b0, 1'b1, 32'h0040_0300, 1'b1, 1'b0, 32'h1001_00C0, '0);
        checkOutput("order_count", gnt_log.size(), 32'd4);
        if (gnt_log.size() >= 4) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            checkOutput("order_0", 32'(gnt_log[0]), 32'd1);
            checkOutput("order_1", 32'(gnt_log[1]), 32'd0);
            checkOutput("order_2", 32'(gnt_log[2]), 32'd1);
            checkOutput("order_3", 32'(gnt_log[3]), 32'd0);
`else
            checkOutput("order_0", 32'(gnt_log[0]), 32'd1);
            checkOutput("order_1", 32'(gnt_log[1]), 32'd1);
            checkOutput("order_2", 32'(gnt_log[2]), 32'd1);
            checkOutput("order_3", 32'(gnt_log[3]), 32'd1);
`endif
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, $urandom,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
